// File: rtl/ofm_pkg.sv
// Shared types and default geometry for the OFM read-back engine.
package ofm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int OFM_ROWS = 13;
    localparam int OFM_COLS = 13;
    localparam int OFM_BASE = 0;

endpackage

// File: rtl/ofm_reader_if.sv
// OFM memory read port plus the outgoing valid/ready word stream.
interface ofm_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last_row;
    logic              out_last;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_last_row, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_last_row, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/ofm_skid_fifo.sv
// Two-entry first-word-fall-through FIFO that absorbs downstream stalls.
// The head entry is always visible; push and pop may happen together.
module ofm_skid_fifo #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_word,
    input  logic             pop,
    output logic [WIDTH-1:0] head_word,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slots [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fill;
    logic             push_ok;
    logic             pop_ok;

    // Never write into a full FIFO unless the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop && (fill != 2'd0);
        push_ok = push && ((fill != 2'd2) || pop_ok);
    end

    // Storage, pointers and occupancy; everything clears on reset so outputs read 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots[0] <= '0;
            slots[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fill     <= 2'd0;
        end else begin
            if (push_ok) begin
                slots[wr_ptr] <= push_word;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            fill <= fill + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign head_word = slots[rd_ptr];
    assign count     = fill;

endmodule

// File: rtl/ofm_reader.sv
// Sweeps the OFM region in raster order and streams each word with
// row/frame boundary flags. A credit check against the skid FIFO keeps at
// most two words outstanding so back-pressure never drops or repeats data.
module ofm_reader
    import ofm_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int BASE   = OFM_BASE,
    parameter int COLS   = OFM_COLS,
    parameter int ROWS   = OFM_ROWS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    ofm_reader_if.master bus
);

    localparam int AW1 = ADDR_W + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              armed;
    logic              inflight;
    logic              pend_last_row;
    logic              pend_last;
    logic [1:0]        fifo_count;
    logic [DATA_W+1:0] head;
    logic              pop;
    logic              issue;
    logic              credit_ok;
    logic [2:0]        occupancy;
    logic              at_last_col;
    logic              at_last_row;
    logic              take_start;
    logic [ADDR_W:0]   addr_wide;

    // Start is only honoured once a clock edge has passed since reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Credit: words in the FIFO plus the read in flight, less any word leaving now.
    always_comb begin
        pop         = bus.out_valid && bus.out_ready;
        occupancy   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        credit_ok   = occupancy < 3'd2;
        issue       = (state == READ) && credit_ok;
        at_last_col = (col == ADDR_W'(COLS - 1));
        at_last_row = (row == ADDR_W'(ROWS - 1));
        take_start  = (state == IDLE) && start && armed;
        addr_wide   = AW1'(BASE) + AW1'(row) * AW1'(COLS) + AW1'(col);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; DRAIN leaves as soon as the last word is on its way out.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (take_start) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (issue && at_last_col && at_last_row) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster counters: cleared on start, advanced by every issued read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (take_start) begin
            row <= '0;
            col <= '0;
        end else if (issue) begin
            if (at_last_col) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Flags ride alongside the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight      <= 1'b0;
            pend_last_row <= 1'b0;
            pend_last     <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pend_last_row <= at_last_col;
                pend_last     <= at_last_col && at_last_row;
            end
        end
    end

    ofm_skid_fifo #(
        .WIDTH (DATA_W + 2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_word ({pend_last, pend_last_row, bus.rd_data}),
        .pop       (pop),
        .head_word (head),
        .count     (fifo_count)
    );

    assign bus.rd_en        = issue;
    assign bus.rd_addr      = issue ? addr_wide[ADDR_W-1:0] : '0;
    assign bus.out_valid    = (fifo_count != 2'd0);
    assign bus.out_data     = head[DATA_W-1:0];
    assign bus.out_last_row = head[DATA_W];
    assign bus.out_last     = head[DATA_W+1];

endmodule

// File: tb/tb_ofm_reader.sv
// Bench for ofm_reader: a scoreboard on the 13x13 instance (full rate,
// random back-pressure, start while busy, mid-frame reset) and a cycle
// table on a small BASE=40, 2x3 instance.
module tb_ofm_reader;
    import ofm_pkg::*;

    localparam int ROWS  = OFM_ROWS;
    localparam int COLS  = OFM_COLS;
    localparam int WORDS = ROWS * COLS;

    typedef struct packed {
        logic [7:0] data;
        logic       last_row;
        logic       last;
    } exp_t;

    typedef struct {
        int         cyc;
        bit         rd_en;
        logic [7:0] addr;
        bit         busy;
        bit         valid;
        logic [7:0] data;
        bit         last_row;
        bit         last;
        bit         done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    logic [7:0] mem [256];

    int   checks = 0;
    int   passed = 0;
    int   reads = 0;
    int   xfers = 0;
    int   outstanding = 0;
    bit   pop_now;
    logic held_valid = 1'b0;
    logic [9:0] held_word = '0;
    exp_t sb [$];
    exp_t e;

    ofm_reader_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
    ofm_reader_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

    ofm_reader #(
        .ADDR_W (8), .DATA_W (8), .BASE (OFM_BASE), .COLS (OFM_COLS), .ROWS (OFM_ROWS)
    ) dut_a (
        .clk (clk), .rst (rst), .start (start_a), .busy (busy_a), .done (done_a), .bus (bus_a)
    );

    ofm_reader #(
        .ADDR_W (8), .DATA_W (8), .BASE (40), .COLS (3), .ROWS (2)
    ) dut_b (
        .clk (clk), .rst (rst), .start (start_b), .busy (busy_b), .done (done_b), .bus (bus_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Synchronous-read OFM memory models, one per instance.
    always @(posedge clk) begin
        if (bus_a.rd_en) bus_a.rd_data <= mem[bus_a.rd_addr];
        if (bus_b.rd_en) bus_b.rd_data <= mem[bus_b.rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream monitor on instance A: scoreboard pops, stall stability, credit limit.
    always @(negedge clk) begin
        if (!rst) begin
            held_valid  = 1'b0;
            outstanding = 0;
        end else begin
            pop_now = bus_a.out_valid && bus_a.out_ready;
            if (held_valid && bus_a.out_valid) begin
                check("stall_stable", {bus_a.out_last, bus_a.out_last_row, bus_a.out_data}, held_word);
            end
            if (bus_a.rd_en) begin
                reads++;
                check("credit_limit", ((outstanding - int'(pop_now)) < 2) ? 1 : 0, 1);
            end
            if (pop_now) begin
                xfers++;
                check("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("word", {bus_a.out_last, bus_a.out_last_row, bus_a.out_data},
                          {e.last, e.last_row, e.data});
                end
            end
            outstanding = outstanding + int'(bus_a.rd_en) - int'(pop_now);
            held_valid  = bus_a.out_valid && !bus_a.out_ready;
            held_word   = {bus_a.out_last, bus_a.out_last_row, bus_a.out_data};
        end
    end

    task automatic push_frame();
        exp_t w;
        for (int i = 0; i < WORDS; i++) begin
            w.data     = i[7:0];
            w.last_row = ((i % COLS) == COLS - 1);
            w.last     = (i == WORDS - 1);
            sb.push_back(w);
        end
    endtask

    // Runs one frame on A from cycle 0 (caller sits just after a clock edge).
    task automatic apply_stimulus(input int ready_pct, input bit poke, output int done_cyc,
                                  output int first_cyc);
        int reads_base;
        int xfers_base;
        int gaps;
        int stray;
        reads_base = reads;
        xfers_base = xfers;
        gaps       = 0;
        stray      = 0;
        done_cyc   = -1;
        first_cyc  = -1;
        push_frame();
        start_a         = 1'b1;
        bus_a.out_ready = ($urandom_range(0, 99) < ready_pct);
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk);
            #1;
            start_a         = 1'b0;
            bus_a.out_ready = ($urandom_range(0, 99) < ready_pct);
            if (c == 1) begin
                check("busy_cycle1", busy_a, 1);
                check("first_read", {bus_a.rd_en, bus_a.rd_addr}, {1'b1, 8'd0});
            end
            if (poke && c == 60) start_a = 1'b1;
            if (first_cyc < 0 && bus_a.out_valid) first_cyc = c;
            if (c >= 3 && c <= WORDS + 2 && !bus_a.out_valid) gaps++;
            if (done_a) begin
                done_cyc = c;
                check("busy_low_at_done", busy_a, 0);
                if (poke) start_a = 1'b1;
                break;
            end
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            if (bus_a.rd_en || busy_a || bus_a.out_valid) stray++;
        end
        check("done_seen", (done_cyc > 0) ? 1 : 0, 1);
        check("quiet_after_frame", stray, 0);
        check("frame_reads", reads - reads_base, WORDS);
        check("frame_xfers", xfers - xfers_base, WORDS);
        check("sb_drained", sb.size(), 0);
        if (ready_pct >= 100) check("full_rate_gaps", gaps, 0);
    endtask

    task automatic check_output(input vec_t v);
        string tag;
        tag = $sformatf("b_cycle%0d", v.cyc);
        check({tag, "_ctrl"}, {busy_b, done_b, bus_b.rd_en, bus_b.out_valid},
              {v.busy, v.done, v.rd_en, v.valid});
        if (v.rd_en) check({tag, "_addr"}, bus_b.rd_addr, v.addr);
        if (v.valid) check({tag, "_word"}, {bus_b.out_last, bus_b.out_last_row, bus_b.out_data},
                           {v.last, v.last_row, v.data});
    endtask

    initial begin
        vec_t vecs [10];
        int   done_cyc;
        int   first_cyc;
        int   guard;

        vecs[0] = '{1,  1, 8'd40, 1, 0, 8'd0,  0, 0, 0};
        vecs[1] = '{2,  1, 8'd41, 1, 0, 8'd0,  0, 0, 0};
        vecs[2] = '{3,  1, 8'd42, 1, 1, 8'd40, 0, 0, 0};
        vecs[3] = '{4,  1, 8'd43, 1, 1, 8'd41, 0, 0, 0};
        vecs[4] = '{5,  1, 8'd44, 1, 1, 8'd42, 1, 0, 0};
        vecs[5] = '{6,  1, 8'd45, 1, 1, 8'd43, 0, 0, 0};
        vecs[6] = '{7,  0, 8'd0,  1, 1, 8'd44, 0, 0, 0};
        vecs[7] = '{8,  0, 8'd0,  1, 1, 8'd45, 1, 1, 0};
        vecs[8] = '{9,  0, 8'd0,  0, 0, 8'd0,  0, 0, 1};
        vecs[9] = '{10, 0, 8'd0,  0, 0, 8'd0,  0, 0, 0};

        for (int a = 0; a < 256; a++) mem[a] = a[7:0];
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {busy_a, done_a, bus_a.rd_en, bus_a.rd_addr, bus_a.out_valid,
                          bus_a.out_data, bus_a.out_last_row, bus_a.out_last}, 0);
        check("reset_b", {busy_b, done_b, bus_b.rd_en, bus_b.rd_addr, bus_b.out_valid,
                          bus_b.out_data, bus_b.out_last_row, bus_b.out_last}, 0);

        // Start in the reset-release cycle must be ignored.
        rst     = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("start_at_release", {busy_a, bus_a.rd_en}, 0);
        repeat (2) @(posedge clk);
        #1;

        // Full rate, with start poked mid-frame and in FIN.
        apply_stimulus(100, 1'b1, done_cyc, first_cyc);
        check("full_first_valid", first_cyc, 3);
        check("full_done_cycle", done_cyc, WORDS + 3);

        // Random back-pressure, ready high about 30% of cycles.
        apply_stimulus(30, 1'b0, done_cyc, first_cyc);

        // Mid-frame reset with the FIFO full.
        push_frame();
        start_a         = 1'b1;
        bus_a.out_ready = 1'b1;
        guard           = 0;
        xfers           = 0;
        while (xfers < 50 && guard < 300) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            guard++;
        end
        check("reached_50_xfers", xfers, 50);
        bus_a.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stalled_valid", bus_a.out_valid, 1);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {busy_a, done_a, bus_a.rd_en, bus_a.rd_addr, bus_a.out_valid,
                                      bus_a.out_data, bus_a.out_last_row, bus_a.out_last}, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst             = 1'b1;
        bus_a.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset", {busy_a, bus_a.rd_en, bus_a.out_valid}, 0);
        apply_stimulus(100, 1'b0, done_cyc, first_cyc);
        check("restart_first_valid", first_cyc, 3);
        check("restart_done_cycle", done_cyc, WORDS + 3);

        // Small geometry at a non-zero base, cycle by cycle.
        bus_b.out_ready = 1'b1;
        start_b         = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            check_output(vecs[i]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
